// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM encoding and default parameters for the uart_send arbiter
package uart_tx_arbiter_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_START_TIMEOUT = 15;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    FRAME = 2'd2
  } state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bundle plus the uart_send-facing signals of the arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = uart_tx_arbiter_pkg::DEF_NUM_REQ
);
  localparam int W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_ready;
  logic                 busy;
  logic [W-1:0]         grant_id;
  logic                 err_timeout;
  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_data, tx_start, busy, grant_id, err_timeout
  );
  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_data, tx_start, busy, grant_id, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick (rotate by pointer, priority-encode, un-rotate)
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] win
);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  // rotate so the pointer lands on bit 0, then take the lowest set bit
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < N; i++) rot[i] = req[(int'(ptr) + i) % N];
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
  end
  assign any = |req;
  assign win = W'((int'(ptr) + int'(off)) % N);
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_send transmitter between byte producers
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int W = $clog2(NUM_REQ);
  localparam logic [W-1:0] LAST = W'(NUM_REQ - 1);
  localparam logic [7:0] TMAX = 8'(START_TIMEOUT - 1);
  state_t state, state_n;
  logic [W-1:0] ptr, ptr_n, grant_n, win, nxt;
  logic [7:0] cnt, cnt_n, data_n;
  logic [NUM_REQ-1:0] ready_n;
  logic any, start_n, busy_n, err_n;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(bus.req_valid),
    .ptr(ptr),
    .any(any),
    .win(win)
  );
  assign nxt = (bus.grant_id == LAST) ? '0 : bus.grant_id + 1'b1;
  // next-state and next-output decode; outputs hold unless a transition changes them
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    grant_n = bus.grant_id;
    data_n = bus.tx_data;
    start_n = bus.tx_start;
    busy_n = bus.busy;
    err_n = bus.err_timeout;
    ready_n = '0;
    unique case (state)
      IDLE: if (bus.tx_ready && any) begin
        state_n = START;
        data_n = bus.req_data[8*win +: 8];
        start_n = 1'b1;
        ready_n = NUM_REQ'(1) << win;
        grant_n = win;
        busy_n = 1'b1;
        cnt_n = '0;
      end
      START: if (!bus.tx_ready) begin
        state_n = FRAME;
        start_n = 1'b0;
      end else if (cnt == TMAX) begin
        state_n = IDLE;
        err_n = 1'b1;
        start_n = 1'b0;
        busy_n = 1'b0;
        ptr_n = nxt;
      end else begin
        cnt_n = cnt + 8'd1;
      end
      FRAME: if (bus.tx_ready) begin
        state_n = IDLE;
        busy_n = 1'b0;
        ptr_n = nxt;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, pointer, counter and all outputs are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      bus.req_ready <= '0;
      bus.tx_data <= 8'h00;
      bus.tx_start <= 1'b0;
      bus.busy <= 1'b0;
      bus.grant_id <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      bus.req_ready <= ready_n;
      bus.tx_data <= data_n;
      bus.tx_start <= start_n;
      bus.busy <= busy_n;
      bus.grant_id <= grant_n;
      bus.err_timeout <= err_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: arbiter with a behavioural uart_send (11 cycles/bit) and a serial-line scoreboard
module tb_uart_tx_arbiter;
  typedef struct {
    logic [3:0] valid;
    int         w;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stub = 1'b0;
  logic tx = 1'b1;
  logic m_busy = 1'b0;
  logic m_ready = 1'b1;
  int m_cnt = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_low = 0;
  int r1_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] dec_b;
  vec_t tbl[11];
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();
  uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  assign bus.tx_ready = stub | m_ready;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic txbit(input int c, input logic [7:0] d);
    int k;
    k = c / 11;
    return (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
  endfunction
  // uart_send model: start on start_send while idle, 10 bits of 11 cycles, re-reads data_byte every cycle
  always @(posedge clk) begin
    if (!m_busy) begin
      if (bus.tx_start && !stub) begin
        m_busy <= 1'b1;
        m_cnt <= 0;
        m_ready <= 1'b0;
        tx <= 1'b0;
      end
    end else if (m_cnt == 109) begin
      m_busy <= 1'b0;
      m_ready <= 1'b1;
      tx <= 1'b1;
    end else begin
      m_cnt <= m_cnt + 1;
      tx <= txbit(m_cnt + 1, bus.tx_data);
    end
  end
  // cycle stamp and last cycle the transmitter was seen busy
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.tx_ready) last_low <= cyc;
  end
  // accept pulses must be one-hot; track requester 1 accepts
  always @(negedge clk) begin
    if (bus.req_ready != 4'b0) begin
      if (bus.req_ready[1]) r1_cnt++;
      chk("req_ready_onehot", $countones(bus.req_ready), 1);
    end
  end
  // serial decoder: sample each bit mid-cell and pop the scoreboard
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!tx) begin
        repeat (5) @(posedge clk);
        #1;
        chk("start_bit", {31'b0, tx}, 0);
        for (int j = 0; j < 8; j++) begin
          repeat (11) @(posedge clk);
          #1;
          dec_b[j] = tx;
        end
        repeat (11) @(posedge clk);
        #1;
        chk("stop_bit", {31'b0, tx}, 1);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got byte %0h expected no frame", dec_b);
        end else chk("frame_byte", {24'b0, dec_b}, {24'b0, q.pop_front()});
      end
    end
  end
  task automatic wait_grant(output int idle);
    bit ok;
    ok = 1'b0;
    idle = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk); #1;
      ok = |bus.req_ready;
      if (!ok && !bus.busy) idle++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: got no req_ready in 400 cycles expected a grant");
    end
  endtask
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk); #1;
      ok = !bus.busy;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy for 400 cycles expected busy low");
    end
  endtask
  initial begin
    int idle, n, bc, r1_before;
    tbl[0] = '{4'hF, 0};
    tbl[1] = '{4'hF, 1};
    tbl[2] = '{4'hF, 2};
    tbl[3] = '{4'hF, 3};
    tbl[4] = '{4'hF, 0};
    tbl[5] = '{4'h8, 3};
    tbl[6] = '{4'h4, 2};
    tbl[7] = '{4'h5, 0};
    tbl[8] = '{4'hA, 1};
    tbl[9] = '{4'h9, 3};
    tbl[10] = '{4'h6, 1};
    bus.req_valid = 4'b0;
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'h58};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {28'b0, bus.req_ready}, 0);
    chk("rst_tx_start", {31'b0, bus.tx_start}, 0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_grant_id", {30'b0, bus.grant_id}, 0);
    chk("rst_err", {31'b0, bus.err_timeout}, 0);
    rst = 1'b0;
    // single request, full frame timing
    bus.req_valid = 4'b0001;
    wait_grant(idle);
    chk("t1_req_ready", {28'b0, bus.req_ready}, 1);
    chk("t1_tx_data", {24'b0, bus.tx_data}, 32'h58);
    chk("t1_busy", {31'b0, bus.busy}, 1);
    q.push_back(8'h58);
    bus.req_valid = 4'b0;
    n = 1;
    bc = 1;
    for (int k = 0; k < 300 && bus.busy; k++) begin
      @(posedge clk); #1;
      if (bus.busy) bc++;
      if (bus.tx_start) n++;
    end
    chk("t1_tx_start_cycles", n, 2);
    chk("t1_busy_cycles", bc, 112);
    bus.req_data[7:0] = 8'hA0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    // round-robin vectors, requests re-presented as soon as the previous one is accepted
    for (int i = 0; i < 11; i++) begin
      bus.req_valid = tbl[i].valid;
      wait_grant(idle);
      chk("tbl_req_ready", {28'b0, bus.req_ready}, 32'(1) << tbl[i].w);
      chk("tbl_grant_id", {30'b0, bus.grant_id}, tbl[i].w);
      chk("tbl_tx_data", {24'b0, bus.tx_data}, 32'hA0 + tbl[i].w);
      if (i > 0) chk("tbl_gap", idle, 1);
      q.push_back(8'(8'hA0 + tbl[i].w));
      bus.req_valid = 4'b0;
    end
    wait_idle();
    // start timeout with tx_ready stuck high
    stub = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 4'b0010;
    wait_grant(idle);
    chk("to_req_ready", {28'b0, bus.req_ready}, 2);
    chk("to_err_before", {31'b0, bus.err_timeout}, 0);
    bus.req_valid = 4'b0;
    n = 1;
    for (int k = 0; k < 100 && bus.busy; k++) begin
      @(posedge clk); #1;
      if (bus.tx_start) n++;
    end
    chk("to_start_cycles", n, 15);
    chk("to_err", {31'b0, bus.err_timeout}, 1);
    chk("to_busy", {31'b0, bus.busy}, 0);
    chk("to_tx_start", {31'b0, bus.tx_start}, 0);
    bus.req_valid = 4'b0011;
    wait_grant(idle);
    chk("to_next_grant", {28'b0, bus.req_ready}, 1);
    bus.req_valid = 4'b0;
    wait_idle();
    chk("to_err_sticky", {31'b0, bus.err_timeout}, 1);
    stub = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_cleared", {31'b0, bus.err_timeout}, 0);
    // asynchronous reset in the middle of a frame
    bus.req_valid = 4'b0001;
    wait_grant(idle);
    chk("rf_grant", {28'b0, bus.req_ready}, 1);
    // the transmitter keeps re-reading data_byte, which reset clears before any 1 bit of A0 goes out
    q.push_back(8'h00);
    bus.req_valid = 4'b0;
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rf_busy", {31'b0, bus.busy}, 0);
    chk("rf_tx_start", {31'b0, bus.tx_start}, 0);
    chk("rf_tx_data", {24'b0, bus.tx_data}, 0);
    chk("rf_grant_id", {30'b0, bus.grant_id}, 0);
    bus.req_valid = 4'b1000;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_grant(idle);
    chk("rf_req_ready", {28'b0, bus.req_ready}, 8);
    chk("rf_wait_tx_ready", cyc - last_low, 2);
    q.push_back(8'hA3);
    bus.req_valid = 4'b0;
    // one-cycle request pulse during a frame is never accepted
    r1_before = r1_cnt;
    repeat (20) @(posedge clk);
    #1;
    bus.req_valid = 4'b0010;
    @(posedge clk); #1;
    bus.req_valid = 4'b0;
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    chk("pulse_no_accept", r1_cnt, r1_before);
    chk("pulse_busy", {31'b0, bus.busy}, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
